// File: rtl/conso_dyn_bd.sv
// Dynamic-energy measurement board for a behavioural AND2 cell.
// Streams per-event supply energy and reports windowed internal energy.
module conso_dyn_bd #(
  parameter int unsigned VDD2_Q      = 12390,
  parameter int unsigned E_INT0      = 2000,
  parameter int unsigned K_TT        = 10,
  parameter int unsigned SPREAD_LOG2 = 2,
  parameter int unsigned ACC_W       = 40
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din1,
  input  logic               din2,
  input  logic               start_tick,
  input  logic               stop_tick,
  input  logic [15:0]        tt_val,
  input  logic [15:0]        capa_charge_val,
  input  logic               fin_test,
  output logic [31:0]        intensity,
  output logic signed [31:0] internal_energy
);

  logic din1_q, din2_q, start_q, stop_q, dout_q;
  logic armed, stop_pend;
  logic dout, ev, rise, start_tg, stop_tg;
  logic [31:0] pend, slice, d;
  logic [31:0] e_int, e_load, e_tot;
  logic [31:0] p_rem, p_new, p_shr, s_new;
  logic [47:0] load_prod;
  logic [ACC_W-1:0] acc_sup, acc_load;
  logic [ACC_W-1:0] sup_start, sup_stop;
  logic [ACC_W-1:0] load_start, load_stop;

  // armed masks the first edge after reset so held inputs cause no event
  assign dout     = din1 & din2;
  assign ev       = armed && !fin_test &&
                    ({din1, din2} != {din1_q, din2_q});
  assign rise     = dout & ~dout_q;
  assign start_tg = armed && !fin_test && (start_tick != start_q);
  assign stop_tg  = armed && !fin_test && (stop_tick != stop_q);

  assign e_int     = 32'(E_INT0) + 32'(K_TT) * {16'd0, tt_val};
  assign load_prod = {32'd0, capa_charge_val} * 48'(VDD2_Q);
  assign e_load    = rise ? 32'(load_prod >> 10) : '0;
  assign e_tot     = e_int + e_load;

  assign d     = (pend < slice) ? pend : slice;
  assign p_rem = pend - d;
  assign p_new = p_rem + e_tot;
  assign p_shr = p_new >> SPREAD_LOG2;
  assign s_new = (p_shr == '0) ? 32'd1 : p_shr;

  assign intensity = fin_test ? '0 : d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din1_q          <= 1'b0;
      din2_q          <= 1'b0;
      start_q         <= 1'b0;
      stop_q          <= 1'b0;
      dout_q          <= 1'b0;
      armed           <= 1'b0;
      stop_pend       <= 1'b0;
      pend            <= '0;
      slice           <= '0;
      acc_sup         <= '0;
      acc_load        <= '0;
      sup_start       <= '0;
      sup_stop        <= '0;
      load_start      <= '0;
      load_stop       <= '0;
      internal_energy <= '0;
    end else begin
      din1_q  <= din1;
      din2_q  <= din2;
      start_q <= start_tick;
      stop_q  <= stop_tick;
      dout_q  <= dout;
      armed   <= 1'b1;
      if (fin_test) begin
        pend <= '0;
      end else begin
        acc_sup <= acc_sup + ACC_W'(d);
        if (ev) begin
          pend     <= p_new;
          slice    <= s_new;
          acc_load <= acc_load + ACC_W'(e_load);
        end else begin
          pend <= p_rem;
        end
        if (start_tg) begin
          sup_start  <= acc_sup;
          load_start <= acc_load;
        end
        if (stop_tg) begin
          sup_stop  <= acc_sup;
          load_stop <= acc_load;
        end
        stop_pend <= stop_tg;
        if (stop_pend)
          internal_energy <= 32'((sup_stop - sup_start) -
                                 (load_stop - load_start));
      end
    end
  end

endmodule

// File: tb/tb_conso_dyn_bd.sv
// Directed bench for conso_dyn_bd.
// Each task drives one scenario and checks against hand-computed values.
module tb_conso_dyn_bd;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din1 = 1'b0;
  logic din2 = 1'b0;
  logic start_tick = 1'b0;
  logic stop_tick = 1'b0;
  logic fin_test = 1'b0;
  logic [15:0] tt_val = 16'd100;
  logic [15:0] capa_charge_val = 16'd379;
  logic [31:0] intensity;
  logic signed [31:0] internal_energy;

  int errors = 0;
  int checks = 0;
  int seq [8];
  int sum;
  int mx;
  int held;

  always #5 clk = ~clk;

  conso_dyn_bd dut (
    .clk(clk),
    .rst_n(rst_n),
    .din1(din1),
    .din2(din2),
    .start_tick(start_tick),
    .stop_tick(stop_tick),
    .tt_val(tt_val),
    .capa_charge_val(capa_charge_val),
    .fin_test(fin_test),
    .intensity(intensity),
    .internal_energy(internal_energy)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // start toggle, input change, 8 captured cycles, stop toggle, result
  task automatic run_window(input logic n1, input logic n2);
    start_tick = ~start_tick;
    cyc(1);
    din1 = n1;
    din2 = n2;
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      seq[i] = int'(intensity);
      sum += seq[i];
    end
    stop_tick = ~stop_tick;
    cyc(2);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    checks++;
    if (intensity !== 32'd0) begin
      errors++;
      $display("FAIL reset_intensity: got %0d expected 0", intensity);
    end
    checks++;
    if (internal_energy !== 32'sd0) begin
      errors++;
      $display("FAIL reset_ie: got %0d expected 0", internal_energy);
    end
    run_window(1'b1, 1'b0);
    checks++;
    if (internal_energy !== 32'sd3000) begin
      errors++;
      $display("FAIL pre_reset_ie: got %0d expected 3000",
               internal_energy);
    end
    din2 = 1'b1;
    cyc(2);
    checks++;
    if (intensity !== 32'd1896) begin
      errors++;
      $display("FAIL mid_delivery: got %0d expected 1896", intensity);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (intensity !== 32'd0 || internal_energy !== 32'sd0) begin
      errors++;
      $display("FAIL async_reset: got %0d/%0d expected 0/0",
               intensity, internal_energy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mx = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (int'(intensity) > mx) mx = int'(intensity);
    end
    checks++;
    if (mx !== 0) begin
      errors++;
      $display("FAIL no_event_after_reset: got %0d expected 0", mx);
    end
  endtask

  task automatic test_a1_fall;
    tt_val = 16'd100;
    capa_charge_val = 16'd379;
    run_window(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seq[i] !== 750) begin
        errors++;
        $display("FAIL fall_seq%0d: got %0d expected 750", i, seq[i]);
      end
    end
    checks++;
    if (seq[4] !== 0) begin
      errors++;
      $display("FAIL fall_seq4: got %0d expected 0", seq[4]);
    end
    checks++;
    if (internal_energy !== 32'sd3000) begin
      errors++;
      $display("FAIL fall_ie: got %0d expected 3000", internal_energy);
    end
  endtask

  task automatic test_a1_rise;
    run_window(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seq[i] !== 1896) begin
        errors++;
        $display("FAIL rise_seq%0d: got %0d expected 1896", i, seq[i]);
      end
    end
    checks++;
    if (seq[4] !== 1 || seq[5] !== 0) begin
      errors++;
      $display("FAIL rise_tail: got %0d,%0d expected 1,0",
               seq[4], seq[5]);
    end
    checks++;
    if (internal_energy !== 32'sd3000) begin
      errors++;
      $display("FAIL rise_ie: got %0d expected 3000", internal_energy);
    end
  endtask

  task automatic test_sweep;
    tt_val = 16'd1;
    capa_charge_val = 16'd37;
    run_window(1'b0, 1'b1);
    checks++;
    if (seq[0] !== 502 || seq[4] !== 2) begin
      errors++;
      $display("FAIL sweep_lo_seq: got %0d,%0d expected 502,2",
               seq[0], seq[4]);
    end
    checks++;
    if (internal_energy !== 32'sd2010) begin
      errors++;
      $display("FAIL sweep_lo_ie: got %0d expected 2010",
               internal_energy);
    end
    tt_val = 16'd199;
    capa_charge_val = 16'd6073;
    run_window(1'b1, 1'b1);
    checks++;
    if (sum !== 77470) begin
      errors++;
      $display("FAIL sweep_hi_sum: got %0d expected 77470", sum);
    end
    checks++;
    if (seq[0] !== 19367 || seq[4] !== 2) begin
      errors++;
      $display("FAIL sweep_hi_seq: got %0d,%0d expected 19367,2",
               seq[0], seq[4]);
    end
    checks++;
    if (internal_energy !== 32'sd3990) begin
      errors++;
      $display("FAIL sweep_hi_ie: got %0d expected 3990",
               internal_energy);
    end
  endtask

  task automatic test_simultaneous;
    tt_val = 16'd100;
    capa_charge_val = 16'd379;
    run_window(1'b0, 1'b0);
    checks++;
    if (sum !== 3000 || seq[0] !== 750) begin
      errors++;
      $display("FAIL both_fall: got sum %0d first %0d expected 3000 750",
               sum, seq[0]);
    end
    run_window(1'b1, 1'b1);
    checks++;
    if (sum !== 7585 || seq[0] !== 1896) begin
      errors++;
      $display("FAIL both_rise: got sum %0d first %0d expected 7585 1896",
               sum, seq[0]);
    end
    checks++;
    if (internal_energy !== 32'sd3000) begin
      errors++;
      $display("FAIL both_rise_ie: got %0d expected 3000",
               internal_energy);
    end
    start_tick = ~start_tick;
    stop_tick = ~stop_tick;
    cyc(3);
    checks++;
    if (internal_energy !== 32'sd0) begin
      errors++;
      $display("FAIL start_stop_same: got %0d expected 0",
               internal_energy);
    end
  endtask

  task automatic test_fin;
    run_window(1'b0, 1'b1);
    checks++;
    if (internal_energy !== 32'sd3000) begin
      errors++;
      $display("FAIL fin_pre_ie: got %0d expected 3000",
               internal_energy);
    end
    fin_test = 1'b1;
    cyc(1);
    din1 = 1'b1;
    stop_tick = ~stop_tick;
    mx = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (int'(intensity) > mx) mx = int'(intensity);
    end
    held = int'(internal_energy);
    checks++;
    if (mx !== 0) begin
      errors++;
      $display("FAIL fin_intensity: got %0d expected 0", mx);
    end
    checks++;
    if (held !== 3000) begin
      errors++;
      $display("FAIL fin_ie_held: got %0d expected 3000", held);
    end
    fin_test = 1'b0;
    mx = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      if (int'(intensity) > mx) mx = int'(intensity);
    end
    checks++;
    if (mx !== 0 || internal_energy !== 32'sd3000) begin
      errors++;
      $display("FAIL fin_release: got %0d/%0d expected 0/3000",
               mx, internal_energy);
    end
    tt_val = 16'd1;
    capa_charge_val = 16'd37;
    run_window(1'b0, 1'b1);
    checks++;
    if (internal_energy !== 32'sd2010) begin
      errors++;
      $display("FAIL fin_after_ie: got %0d expected 2010",
               internal_energy);
    end
  endtask

  initial begin
    test_reset;
    test_a1_fall;
    test_a1_rise;
    test_sweep;
    test_simultaneous;
    test_fin;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
